// File: rtl/mlaccel_qpi_host_pkg.sv
// rtl/mlaccel_qpi_host_pkg.sv - shared types and helpers for the QPI host
package mlaccel_qpi_host_pkg;

    localparam int DIV_W = 4;
    localparam int GAP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        OPEN,
        HOLD,
        GAP
    } state_t;

    function automatic logic [3:0] nibble_sel(input logic [7:0] data, input logic lo_half);
        return lo_half ? data[3:0] : data[7:4];
    endfunction

endpackage

// File: rtl/mlaccel_qpi_defs.vh
// rtl/mlaccel_qpi_defs.vh - QPI accelerator command opcodes shared by host and command decoder
`ifndef MLACCEL_QPI_DEFS_VH
`define MLACCEL_QPI_DEFS_VH
`define MLACCEL_QPI_OP_STATUS 8'h20
`define MLACCEL_QPI_OP_WBUF   8'h21
`define MLACCEL_QPI_OP_RBUF   8'h22
`define MLACCEL_QPI_OP_WMEM   8'h23
`define MLACCEL_QPI_OP_RMEM   8'h24
`define MLACCEL_QPI_OP_RUN    8'h25
`define MLACCEL_QPI_OP_STOP   8'h26
`endif

// File: rtl/mlaccel_qpi_host_div.sv
// rtl/mlaccel_qpi_host_div.sv - CLKDIV phase timer; strobes on the last cycle of each timed phase
module mlaccel_qpi_host_div
    import mlaccel_qpi_host_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic phase_end
);

    logic [DIV_W-1:0] count;

    // Held at zero outside timed states so every phase starts with a full count.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            count <= '0;
        end else if (phase_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign phase_end = run && (count == DIV_W'(CLKDIV - 1));

endmodule

// File: rtl/mlaccel_qpi_host.sv
// rtl/mlaccel_qpi_host.sv - byte-stream QPI host: one nibble per qpi_clk, csb framing and gap
`include "mlaccel_qpi_defs.vh"

module mlaccel_qpi_host
    import mlaccel_qpi_host_pkg::*;
#(
    parameter int CLKDIV  = 2,
    parameter int CSB_GAP = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_last,
    input  logic       cmd_read,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       qpi_csb,
    output logic       qpi_clk,
    output logic [3:0] qpi_io_do,
    output logic [3:0] qpi_io_oe,
    input  logic [3:0] qpi_io_di
);

    state_t             state;
    state_t             state_next;
    logic               run;
    logic               phase_end;
    logic               accept;
    logic               gap_done;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         byte_q;
    logic [7:0]         shreg;
    logic               is_read;
    logic               is_last;
    logic               lo_half;
    logic               pend;
    logic               csb_q;
    logic               clk_q;
    logic               drive;

    mlaccel_qpi_host_div #(.CLKDIV(CLKDIV)) u_div (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .phase_end (phase_end)
    );

    assign run       = (state == SETUP) || (state == LOW) || (state == HIGH) || (state == HOLD);
    assign cmd_ready = !reset && ((state == IDLE) || (state == OPEN));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = !reset && (state != IDLE);
    assign gap_done  = (state == GAP) && (gap_cnt == GAP_W'(CSB_GAP - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SETUP;
            SETUP: if (phase_end) state_next = LOW;
            LOW:   if (phase_end) state_next = HIGH;
            HIGH: begin
                if (phase_end) begin
                    if (!lo_half) begin
                        state_next = LOW;
                    end else if (is_last) begin
                        state_next = HOLD;
                    end else begin
                        state_next = OPEN;
                    end
                end
            end
            OPEN:  if (accept) state_next = cmd_start ? HOLD : LOW;
            HOLD:  if (phase_end) state_next = GAP;
            GAP:   if (gap_done) state_next = pend ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // csb and clk come straight from flops driven by the next state, so the pads never glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            csb_q     <= 1'b1;
            clk_q     <= 1'b0;
            gap_cnt   <= '0;
            byte_q    <= '0;
            shreg     <= '0;
            is_read   <= 1'b0;
            is_last   <= 1'b0;
            lo_half   <= 1'b0;
            pend      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            csb_q     <= (state_next == IDLE) || (state_next == GAP);
            clk_q     <= (state_next == HIGH);
            gap_cnt   <= ((state == GAP) && !gap_done) ? gap_cnt + 1'b1 : '0;
            rsp_valid <= (state == HIGH) && phase_end && lo_half && is_read;

            if (accept) begin
                byte_q  <= cmd_data;
                is_read <= cmd_read;
                is_last <= cmd_last;
                lo_half <= 1'b0;
                pend    <= (state == OPEN) && cmd_start;
            end else begin
                if ((state == HIGH) && phase_end) begin
                    lo_half <= !lo_half;
                end
                if (gap_done) begin
                    pend <= 1'b0;
                end
            end

            if ((state == LOW) && phase_end && is_read) begin
                shreg <= {shreg[3:0], qpi_io_di};
            end
            if ((state == HIGH) && phase_end && lo_half && is_read) begin
                rsp_data <= shreg;
            end
        end
    end

    assign drive     = ((state == LOW) || (state == HIGH)) && !is_read;
    assign qpi_csb   = csb_q;
    assign qpi_clk   = clk_q;
    assign qpi_io_oe = drive ? 4'hF : 4'h0;
    assign qpi_io_do = drive ? nibble_sel(byte_q, lo_half) : 4'h0;

endmodule

// File: tb/tb_mlaccel_qpi_host.sv
// tb/tb_mlaccel_qpi_host.sv - directed self-checking bench for mlaccel_qpi_host
module tb_mlaccel_qpi_host;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    always #5 clock = ~clock;

    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_last = 1'b0, cmd_read = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] qpi_io_di = 4'h0;
    logic       cmd_ready, rsp_valid, busy, qpi_csb, qpi_clk;
    logic [7:0] rsp_data;
    logic [3:0] qpi_io_do, qpi_io_oe;

    logic       c2_valid = 1'b0, c2_start = 1'b0, c2_last = 1'b0, c2_read = 1'b0;
    logic [7:0] c2_data = 8'h00;
    logic [3:0] di2 = 4'h0;
    logic       c2_ready, r2_valid, busy2, csb2, clk2;
    logic [7:0] r2_data;
    logic [3:0] do2, oe2;

    mlaccel_qpi_host #(.CLKDIV(2), .CSB_GAP(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
        .cmd_last(cmd_last), .cmd_read(cmd_read), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .qpi_csb(qpi_csb), .qpi_clk(qpi_clk), .qpi_io_do(qpi_io_do),
        .qpi_io_oe(qpi_io_oe), .qpi_io_di(qpi_io_di)
    );

    mlaccel_qpi_host #(.CLKDIV(15), .CSB_GAP(4)) dut15 (
        .clock(clock), .reset(reset),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_start(c2_start),
        .cmd_last(c2_last), .cmd_read(c2_read), .cmd_data(c2_data),
        .rsp_valid(r2_valid), .rsp_data(r2_data), .busy(busy2),
        .qpi_csb(csb2), .qpi_clk(clk2), .qpi_io_do(do2),
        .qpi_io_oe(oe2), .qpi_io_di(di2)
    );

    int checks = 0;
    int errors = 0;

    // Target-side monitor for the CLKDIV=2 instance.
    int         rises = 0, falls = 0, rsp_cnt = 0, oe_bad = 0;
    int         hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
    logic [7:0] rsp_seen = 8'h00;
    logic [3:0] nib_q[$];
    logic       prev_clk = 1'b0, prev_csb = 1'b1;
    bit         rd_window = 1'b0;

    always @(negedge clock) begin
        if (qpi_clk === 1'b1 && prev_clk === 1'b0) begin
            rises++;
            nib_q.push_back(qpi_io_do);
        end
        if (qpi_csb === 1'b0 && prev_csb === 1'b1) begin
            falls++;
            last_hi = hi_run;
        end
        if (qpi_csb === 1'b1 && prev_csb === 1'b0) last_lo = lo_run;
        if (qpi_csb === 1'b1) begin
            hi_run++;
            lo_run = 0;
        end else begin
            lo_run++;
            hi_run = 0;
        end
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_seen = rsp_data;
        end
        if (rd_window && qpi_io_oe !== 4'h0) oe_bad++;
        prev_clk = qpi_clk;
        prev_csb = qpi_csb;
    end

    task automatic send_byte(input logic start, input logic last, input logic rd, input logic [7:0] data);
        int n = 0;
        cmd_valid = 1'b1; cmd_start = start; cmd_last = last; cmd_read = rd; cmd_data = data;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte ready timeout data=%h got ready=%b want 1", data, cmd_ready);
        end
        @(negedge clock);
        cmd_valid = 1'b0; cmd_start = 1'b0; cmd_last = 1'b0; cmd_read = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy got %b want 0", busy);
        end
        @(negedge clock);
    endtask

    // Per-cycle frame check of a single write from IDLE; s=0 is the first cycle after acceptance.
    task automatic check_frame(input int d, input int g, input logic [7:0] b, input int which);
        logic [11:0] obs, exp;
        logic        e_clk, e_csb, e_busy;
        logic [3:0]  e_oe, e_do;
        for (int s = 0; s <= 6 * d + g; s++) begin
            e_clk  = (s >= 2 * d && s < 3 * d) || (s >= 4 * d && s < 5 * d);
            e_csb  = (s >= 6 * d);
            e_busy = (s < 6 * d + g);
            e_oe   = (s >= d && s < 5 * d) ? 4'hF : 4'h0;
            e_do   = (s >= d && s < 3 * d) ? b[7:4] : ((s >= 3 * d && s < 5 * d) ? b[3:0] : 4'h0);
            exp    = {e_csb, e_clk, e_busy, !e_busy, e_oe, e_do};
            if (which == 0) obs = {qpi_csb, qpi_clk, busy, cmd_ready, qpi_io_oe, qpi_io_do};
            else            obs = {csb2, clk2, busy2, c2_ready, oe2, do2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL frame div=%0d s=%0d {csb,clk,busy,rdy,oe,do} got %h want %h", d, s, obs, exp);
            end
            if (s < 6 * d + g) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({qpi_csb, qpi_clk, qpi_io_oe, qpi_io_do, rsp_valid, rsp_data, busy, cmd_ready} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got csb=%b clk=%b oe=%h do=%h rv=%b rd=%h busy=%b rdy=%b want 1 0 0 0 0 00 0 0",
                     qpi_csb, qpi_clk, qpi_io_oe, qpi_io_do, rsp_valid, rsp_data, busy, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({cmd_ready, c2_ready, busy, qpi_csb} !== 4'b1101) begin
            errors++;
            $display("FAIL reset_release {rdy,rdy2,busy,csb} got %b want 1101", {cmd_ready, c2_ready, busy, qpi_csb});
        end
    endtask

    task automatic test_write_a5();
        int r = rises, n = nib_q.size();
        cmd_valid = 1'b1; cmd_start = 1'b1; cmd_last = 1'b1; cmd_read = 1'b0; cmd_data = 8'hA5;
        @(negedge clock);
        cmd_valid = 1'b0; cmd_start = 1'b0; cmd_last = 1'b0;
        check_frame(2, 4, 8'hA5, 0);
        checks++;
        if (rises - r !== 2 || nib_q[n] !== 4'hA || nib_q[n+1] !== 4'h5) begin
            errors++;
            $display("FAIL write_a5 edges got %0d nibbles %h %h want 2 a 5", rises - r, nib_q[n], nib_q[n+1]);
        end
    endtask

    task automatic test_status();
        int r = rises, n = nib_q.size(), c = rsp_cnt, ob = oe_bad, f = falls;
        qpi_io_di = 4'hF;
        send_byte(1'b1, 1'b0, 1'b0, 8'h20);
        send_byte(1'b0, 1'b1, 1'b1, 8'h00);
        rd_window = 1'b1;
        wait_idle();
        rd_window = 1'b0;
        checks++;
        if (rsp_cnt - c !== 1 || rsp_seen !== 8'hFF || rsp_data !== 8'hFF) begin
            errors++;
            $display("FAIL status_rsp pulses got %0d data %h held %h want 1 ff ff", rsp_cnt - c, rsp_seen, rsp_data);
        end
        checks++;
        if (oe_bad - ob !== 0) begin
            errors++;
            $display("FAIL status_oe driven cycles during read got %0d want 0", oe_bad - ob);
        end
        checks++;
        if (rises - r !== 4 || falls - f !== 1 || nib_q[n] !== 4'h2 || nib_q[n+1] !== 4'h0) begin
            errors++;
            $display("FAIL status_frame rises %0d falls %0d nib %h %h want 4 1 2 0", rises - r, falls - f, nib_q[n], nib_q[n+1]);
        end
    endtask

    task automatic test_read_c3();
        int c = rsp_cnt, k = 0;
        qpi_io_di = 4'hC;
        send_byte(1'b1, 1'b1, 1'b1, 8'h00);
        while (qpi_clk !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        qpi_io_di = 4'h3;
        wait_idle();
        checks++;
        if (rsp_cnt - c !== 1 || rsp_seen !== 8'hC3) begin
            errors++;
            $display("FAIL read_c3 pulses got %0d data %h want 1 c3", rsp_cnt - c, rsp_seen);
        end
    endtask

    task automatic test_back_to_back();
        int r = rises, n = nib_q.size(), f = falls;
        logic [3:0] exp_n [6] = '{4'h2, 4'h1, 4'h3, 4'h4, 4'h1, 4'h2};
        send_byte(1'b1, 1'b0, 1'b0, 8'h21);
        send_byte(1'b0, 1'b0, 1'b0, 8'h34);
        send_byte(1'b0, 1'b1, 1'b0, 8'h12);
        wait_idle();
        checks++;
        if (rises - r !== 6 || falls - f !== 1 || last_lo !== 30) begin
            errors++;
            $display("FAIL b2b_frame rises %0d falls %0d csb_low %0d want 6 1 30", rises - r, falls - f, last_lo);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (nib_q[n+i] !== exp_n[i]) begin
                errors++;
                $display("FAIL b2b_nibble %0d got %h want %h", i, nib_q[n+i], exp_n[i]);
            end
        end
    endtask

    task automatic test_restart();
        int r = rises, n = nib_q.size(), f = falls;
        send_byte(1'b1, 1'b0, 1'b0, 8'h20);
        send_byte(1'b1, 1'b1, 1'b0, 8'h26);
        wait_idle();
        checks++;
        if (falls - f !== 2 || last_hi !== 4 || rises - r !== 4) begin
            errors++;
            $display("FAIL restart_frame falls %0d gap %0d rises %0d want 2 4 4", falls - f, last_hi, rises - r);
        end
        checks++;
        if ({nib_q[n], nib_q[n+1], nib_q[n+2], nib_q[n+3]} !== 16'h2026) begin
            errors++;
            $display("FAIL restart_bytes got %h%h %h%h want 20 26", nib_q[n], nib_q[n+1], nib_q[n+2], nib_q[n+3]);
        end
    endtask

    task automatic test_reset_mid_read();
        int r = rises, c = rsp_cnt, k = 0;
        qpi_io_di = 4'h9;
        send_byte(1'b1, 1'b1, 1'b1, 8'h00);
        while (rises - r < 2 && k < 100) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (qpi_clk !== 1'b1) begin
            errors++;
            $display("FAIL midread_setup clk got %b want 1", qpi_clk);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({qpi_csb, qpi_clk, qpi_io_oe, rsp_valid, cmd_ready} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midread_abort {csb,clk,oe,rv,rdy} got %b want 10000000", {qpi_csb, qpi_clk, qpi_io_oe, rsp_valid, cmd_ready});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({cmd_ready, busy, qpi_csb} !== 3'b101) begin
            errors++;
            $display("FAIL midread_release {rdy,busy,csb} got %b want 101", {cmd_ready, busy, qpi_csb});
        end
        repeat (10) @(negedge clock);
        checks++;
        if (rsp_cnt - c !== 0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL midread_rsp pulses %0d data %h want 0 00", rsp_cnt - c, rsp_data);
        end
    endtask

    task automatic test_clkdiv15();
        c2_valid = 1'b1; c2_start = 1'b1; c2_last = 1'b1; c2_read = 1'b0; c2_data = 8'h5A;
        @(negedge clock);
        c2_valid = 1'b0; c2_start = 1'b0; c2_last = 1'b0;
        check_frame(15, 4, 8'h5A, 1);
    endtask

    initial begin
        test_reset();
        test_write_a5();
        test_status();
        test_read_c3();
        test_back_to_back();
        test_restart();
        test_clkdiv15();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mlaccel_qpi_host.md
MLACCEL_QPI_HOST -- requirements
Module: mlaccel_qpi_host

Interface
REQ-001 Parameter CLKDIV, default 2, meaning the number of clock cycles per qpi_clk half-period (legal range 2..15).
REQ-002 Parameter CSB_GAP, default 4, meaning the minimum number of clock cycles qpi_csb stays high between transactions.
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 cmd_valid  input  1  byte request valid.
REQ-006 cmd_ready  output  1  byte request accepted when valid&&ready.
REQ-007 cmd_start  input  1  byte opens a new transaction (csb falling edge before it).
REQ-008 cmd_last  input  1  close the transaction (csb rising) after this byte.
REQ-009 cmd_read  input  1  0 = drive cmd_data; 1 = tristate and capture a byte.
REQ-010 cmd_data  input  8  byte to send; ignored when cmd_read=1.
REQ-011 rsp_valid  output  1  one-cycle pulse, captured byte available.
REQ-012 rsp_data  output  8  captured byte; held until the next capture.
REQ-013 busy  output  1  high whenever qpi_csb is low or the CSB_GAP period is running.
REQ-014 qpi_csb  output  1  chip select, active low.
REQ-015 qpi_clk  output  1  serial clock; idles low.
REQ-016 qpi_io_do  output  4  nibble driven to the pads.
REQ-017 qpi_io_oe  output  4  per-bit output enable; all bits equal.
REQ-018 qpi_io_di  input  4  nibble from the pads (already synchronous to clock).

Function
REQ-019 The state machine SHALL use the states IDLE, SETUP, LOW, HIGH, OPEN, HOLD, and GAP.
REQ-020 IDLE: csb=1, clk=0, cmd_ready=1; accepting any byte SHALL go to SETUP (cmd_start is implied in IDLE).
REQ-021 SETUP: csb=0, clk=0 for CLKDIV cycles, then go to LOW for the high nibble.
REQ-022 LOW: clk=0 for CLKDIV cycles; io_do=current nibble and oe=4'hF for a write, or oe=0 for a read.
REQ-023 On the last LOW cycle of a read, the block SHALL sample qpi_io_di into the nibble register.
REQ-024 HIGH: clk=1 for CLKDIV cycles; io_do/oe SHALL be held stable; after the high nibble go to LOW (low nibble), after the low nibble go to OPEN or HOLD.
REQ-025 Nibble order SHALL be high nibble first, and a byte SHALL take exactly 4*CLKDIV cycles after SETUP.
REQ-026 For a read, rsp_valid SHALL pulse in the cycle after the low-nibble HIGH phase ends, with rsp_data={first sample, second sample}.
REQ-027 OPEN: csb=0, clk=0, oe=0, cmd_ready=1; a byte accepted with cmd_start=0 SHALL go directly to LOW with no extra cycle.
REQ-028 A byte accepted in OPEN with cmd_start=1 SHALL first run HOLD and GAP, then SETUP, then send the byte; cmd_ready SHALL be 0 from acceptance until OPEN is reached again.
REQ-029 After a byte with cmd_last=1 the block SHALL enter HOLD: csb=0, clk=0, oe=0 for CLKDIV cycles.
REQ-030 HOLD SHALL go to GAP: csb=1 for CSB_GAP cycles, then IDLE.
REQ-031 cmd_ready SHALL be 0 in SETUP, LOW, HIGH, HOLD, and GAP.
REQ-032 A qpi_clk rising edge SHALL occur only from a LOW phase of CLKDIV cycles; no clk glitches are permitted on any state change.
REQ-033 cmd_start=1 together with cmd_last=1 SHALL produce a single-byte transaction.

Reset
REQ-034 During reset: qpi_csb=1, qpi_clk=0, qpi_io_oe=0, qpi_io_do=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0, state=IDLE.
REQ-035 Reset asserted mid-transaction SHALL abort immediately, raise csb in the same cycle, and emit no rsp_valid; the CSB_GAP period is not applied.
REQ-036 cmd_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-037 The command opcodes 8'h20..8'h26 (status, wbuf, rbuf, wmem, rmem, run, stop) SHALL live in the shared include mlaccel_qpi_defs.vh, used by this block and the accelerator command decoder.
REQ-038 A single sub-module, mlaccel_qpi_host_div, SHALL generate the CLKDIV phase-end strobe; the state machine stays in this module.

Verification
REQ-039 CLKDIV=2, write 8'hA5 with start and last from IDLE -> csb low 2 cycles, rising edges with io=4'hA then 4'h5, each nibble stable for 4 cycles around its edge, csb high 2 cycles after the second falling edge, then 4 cycles of busy.
REQ-040 Status transaction: write 8'h20 with start, then read with last while the target model drives 8'hFF -> rsp_valid is pulsed once with rsp_data=8'hFF, and oe=0 throughout the read byte.
REQ-041 Back-to-back writes 8'h21, 8'h34, 8'h12 (start on the first, last on the third) -> no gap between bytes, exactly 6 clk rising edges, and a single csb low period.
REQ-042 cmd_start=1 while OPEN -> csb rises for exactly CSB_GAP cycles before the new byte, and the target model sees two separate start bytes.
REQ-043 Reset asserted during the HIGH phase of a read -> next cycle shows csb=1, clk=0, oe=0, no rsp_valid, and cmd_ready=1 one cycle after reset deasserts.
REQ-044 CLKDIV=15 with 8'h5A -> each clk half-period is exactly 15 cycles and the byte lasts 60 cycles.
